// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for the shared 16-bit data memory.
// Define DMEM_ARB_RR_EN for round-robin tie-break; default is port 0 priority.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  wr0,
    input  logic                  wr1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [15:0]           wdata0,
    input  logic [15:0]           wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  err0,
    output logic                  err1,
    output logic [15:0]           rdata,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
    localparam logic [3:0] LMAX = 4'(LOCK_MAX);

    state_t                  state_q, state_d;
    logic [3:0]              lcnt_q, lcnt_d, lcnt_inc;
    logic                    rv0_q, rv1_q, er0_q, er1_q;
    logic [15:0]             rdata_q;
    logic                    gnt_any, sel_lk, sel_wr, mis;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [15:0]             sel_wd;
`ifdef DMEM_ARB_RR_EN
    logic                    last_q, last_d;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
                        gnt0 = last_q;
                        gnt1 = !last_q;
`else
                        gnt0 = 1'b1;
`endif
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                LOCK0:   gnt0 = req0;
                LOCK1:   gnt1 = req1;
                default: ;
            endcase
        end
    end

    assign gnt_any   = gnt0 | gnt1;
    assign sel_addr  = gnt1 ? addr1 : addr0;
    assign sel_wd    = gnt1 ? wdata1 : wdata0;
    assign sel_wr    = gnt1 ? wr1 : wr0;
    assign sel_lk    = gnt1 ? lock1 : lock0;
    assign mis       = sel_addr[0];

    // Misaligned grants still consume the request but never touch memory
    assign mem_en    = gnt_any & ~mis;
    assign mem_wr    = gnt_any & sel_wr;
    assign mem_addr  = gnt_any ? sel_addr : '0;
    assign mem_wdata = gnt_any ? sel_wd : '0;

    always_comb begin
        state_d  = state_q;
        lcnt_d   = lcnt_q;
        lcnt_inc = lcnt_q + 4'd1;
        unique case (state_q)
            IDLE: begin
                if (gnt_any && sel_lk && LOCK_MAX > 1) begin
                    state_d = gnt1 ? LOCK1 : LOCK0;
                    lcnt_d  = 4'd1;
                end
            end
            LOCK0, LOCK1: begin
                if (!gnt_any || !sel_lk || lcnt_inc >= LMAX) begin
                    state_d = IDLE;
                    lcnt_d  = '0;
                end else begin
                    lcnt_d = lcnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                lcnt_d  = '0;
            end
        endcase
    end

`ifdef DMEM_ARB_RR_EN
    assign last_d = gnt_any ? gnt1 : last_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lcnt_q  <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            er0_q   <= 1'b0;
            er1_q   <= 1'b0;
            rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            rv0_q   <= gnt0 & ~mis & ~sel_wr;
            rv1_q   <= gnt1 & ~mis & ~sel_wr;
            er0_q   <= gnt0 & mis;
            er1_q   <= gnt1 & mis;
            if (gnt_any && !mis && !sel_wr) begin
                rdata_q <= mem_rdata;
            end
`ifdef DMEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign rvalid0 = rv0_q;
    assign rvalid1 = rv1_q;
    assign err0    = er0_q;
    assign err1    = er1_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus random traffic checked against
// a transaction-level model of the arbiter and a reference memory.
module tb_dmem_arbiter;
    localparam int LOCK_MAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 0, req1 = 0, wr0 = 0, wr1 = 0, lock0 = 0, lock1 = 0;
    logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_wr;

    logic [15:0] bmem [0:32767];
    logic [15:0] mref [0:32767];

    int vecs = 0;
    int errs = 0;

    // model state
    int          m_owner = -1;
    int          m_cnt = 0;
    bit          m_rv0, m_rv1, m_er0, m_er1;
    logic [15:0] m_rdata = 0;
`ifdef DMEM_ARB_RR_EN
    int          m_last = 1;
`endif

    always #5 clk = ~clk;

    assign mem_rdata = bmem[mem_addr[15:1]];

    dmem_arbiter #(.ADDR_WIDTH(16), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .err0(err0), .err1(err1), .rdata(rdata),
        .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Which port should win this cycle (-1 = none)
    function automatic int exp_g();
        if (rst) return -1;
        if (m_owner == 0) return req0 ? 0 : -1;
        if (m_owner == 1) return req1 ? 1 : -1;
        if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
            return 1 - m_last;
`else
            return 0;
`endif
        end
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    // {gnt0, gnt1, mem_en, mem_wr, mem_addr, mem_wdata}
    function automatic logic [35:0] exp_comb(int g);
        logic [15:0] a, d;
        logic        w;
        if (g < 0) return '0;
        a = (g == 1) ? addr1 : addr0;
        d = (g == 1) ? wdata1 : wdata0;
        w = (g == 1) ? wr1 : wr0;
        return {g == 0, g == 1, ~a[0], w, a, d};
    endfunction

    function automatic logic [19:0] exp_regs();
        return {m_rv0, m_rv1, m_er0, m_er1, m_rdata};
    endfunction

    task automatic model_edge(int g);
        logic [15:0] a, d;
        logic        w, lk;
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_rdata = 0;
            {m_rv0, m_rv1, m_er0, m_er1} = 4'b0;
`ifdef DMEM_ARB_RR_EN
            m_last = 1;
`endif
            return;
        end
        {m_rv0, m_rv1, m_er0, m_er1} = 4'b0;
        if (g < 0) begin
            m_owner = -1; m_cnt = 0;
            return;
        end
        a  = (g == 1) ? addr1 : addr0;
        d  = (g == 1) ? wdata1 : wdata0;
        w  = (g == 1) ? wr1 : wr0;
        lk = (g == 1) ? lock1 : lock0;
`ifdef DMEM_ARB_RR_EN
        m_last = g;
`endif
        if (a[0]) begin
            if (g == 0) m_er0 = 1; else m_er1 = 1;
        end else if (w) begin
            mref[a[15:1]] = d;
        end else begin
            m_rdata = mref[a[15:1]];
            if (g == 0) m_rv0 = 1; else m_rv1 = 1;
        end
        if (m_owner < 0) begin
            if (lk && LOCK_MAX > 1) begin
                m_owner = g; m_cnt = 1;
            end
        end else begin
            m_cnt++;
            if (!lk || m_cnt >= LOCK_MAX) begin
                m_owner = -1; m_cnt = 0;
            end
        end
    endtask

    // Advance one clock: memory behaves as the real RAM, model follows
    task automatic tick();
        int          g;
        logic        w;
        logic [14:0] wa;
        logic [15:0] wd;
        g  = exp_g();
        w  = mem_en && mem_wr;
        wa = mem_addr[15:1];
        wd = mem_wdata;
        @(posedge clk);
        if (w) bmem[wa] = wd;
        model_edge(g);
        @(negedge clk);
    endtask

    task automatic idle_in();
        {req0, req1, wr0, wr1, lock0, lock1} = 6'b0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0 = 1; req1 = 1; addr0 = 16'h0010; addr1 = 16'h0012;
        #1;
        vecs++;
        if ({gnt0, gnt1, mem_en, mem_wr, mem_addr, mem_wdata} !== 36'h0) begin
            errs++;
            $display("FAIL reset_comb: got %h want 0",
                     {gnt0, gnt1, mem_en, mem_wr, mem_addr, mem_wdata});
        end
        tick();
        tick();
        #1;
        vecs++;
        if ({rvalid0, rvalid1, err0, err1, rdata, gnt0, gnt1, mem_en} !== 23'h0) begin
            errs++;
            $display("FAIL reset_regs: got %h want 0",
                     {rvalid0, rvalid1, err0, err1, rdata, gnt0, gnt1, mem_en});
        end
        rst = 1'b0;
        idle_in();
        @(negedge clk);
    endtask

    task automatic test_read();
        bmem[8] = 16'hBEEF;
        mref[8] = 16'hBEEF;
        idle_in();
        req0 = 1; addr0 = 16'h0010;
        #1;
        vecs++;
        if ({gnt0, gnt1, mem_en, mem_wr, mem_addr} !== {4'b1010, 16'h0010}) begin
            errs++;
            $display("FAIL read_grant: got %h want %h",
                     {gnt0, gnt1, mem_en, mem_wr, mem_addr}, {4'b1010, 16'h0010});
        end
        tick();
        req0 = 0;
        #1;
        vecs++;
        if ({rvalid0, rvalid1, err0, err1, rdata} !== {4'b1000, 16'hBEEF}) begin
            errs++;
            $display("FAIL read_data: got %h want %h",
                     {rvalid0, rvalid1, err0, err1, rdata}, {4'b1000, 16'hBEEF});
        end
        tick();
        #1;
        vecs++;
        if (rvalid0 !== 1'b0) begin
            errs++;
            $display("FAIL read_pulse: rvalid0 got %b want 0", rvalid0);
        end
    endtask

    task automatic test_tie();
        int seq[4];
        int want[4];
`ifdef DMEM_ARB_RR_EN
        want = '{0, 1, 0, 1};
`else
        want = '{0, 0, 0, 0};
`endif
        do_reset();
        req0 = 1; req1 = 1; addr0 = 16'h0100; addr1 = 16'h0102;
        for (int i = 0; i < 4; i++) begin
            #1;
            seq[i] = gnt1 ? 1 : (gnt0 ? 0 : -1);
            vecs++;
            if (seq[i] != want[i]) begin
                errs++;
                $display("FAIL tie_cycle%0d: granted %0d want %0d", i, seq[i], want[i]);
            end
            tick();
        end
        idle_in();
        tick();
    endtask

    task automatic test_lock_rmw();
        do_reset();
        req1 = 1; wr1 = 1; lock1 = 1; addr1 = 16'h0020; wdata1 = 16'h1234;
        #1;
        vecs++;
        if ({gnt0, gnt1, mem_en, mem_wr} !== 4'b0111) begin
            errs++;
            $display("FAIL rmw_write: got %b want 0111", {gnt0, gnt1, mem_en, mem_wr});
        end
        tick();
        wr1 = 0; lock1 = 0;
        req0 = 1; addr0 = 16'h0040;
        #1;
        vecs++;
        if ({gnt0, gnt1, mem_wr, mem_addr} !== {3'b010, 16'h0020}) begin
            errs++;
            $display("FAIL rmw_read: got %h want %h",
                     {gnt0, gnt1, mem_wr, mem_addr}, {3'b010, 16'h0020});
        end
        tick();
        req1 = 0;
        #1;
        vecs++;
        if ({rvalid1, rdata, gnt0, gnt1} !== {1'b1, 16'h1234, 2'b10}) begin
            errs++;
            $display("FAIL rmw_release: got %h want %h",
                     {rvalid1, rdata, gnt0, gnt1}, {1'b1, 16'h1234, 2'b10});
        end
        tick();
        idle_in();
        tick();
    endtask

    task automatic test_lock_max();
        int seq[10];
        int run;
        do_reset();
        req1 = 1; lock1 = 1; addr1 = 16'h0030;
        addr0 = 16'h0032;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) req0 = 1;
            #1;
            seq[i] = gnt1 ? 1 : (gnt0 ? 0 : -1);
            vecs++;
            if ({gnt0, gnt1, mem_en, mem_wr, mem_addr, mem_wdata} !== exp_comb(exp_g())) begin
                errs++;
                $display("FAIL lockmax_comb%0d: got %h want %h", i,
                         {gnt0, gnt1, mem_en, mem_wr, mem_addr, mem_wdata}, exp_comb(exp_g()));
            end
            tick();
        end
        run = 0;
        while (run < 10 && seq[run] == 1) run++;
        vecs++;
        if (run != LOCK_MAX || seq[LOCK_MAX] != 0) begin
            errs++;
            $display("FAIL lock_max: gnt1 run %0d then %0d, want %0d then 0",
                     run, seq[run < 10 ? run : 9], LOCK_MAX);
        end
        idle_in();
        tick();
    endtask

    task automatic test_misaligned();
        logic [15:0] old;
        idle_in();
        old = bmem[16];
        req0 = 1; wr0 = 1; addr0 = 16'h0021; wdata0 = 16'hDEAD;
        #1;
        vecs++;
        if ({gnt0, gnt1, mem_en} !== 3'b100) begin
            errs++;
            $display("FAIL mis_grant: got %b want 100", {gnt0, gnt1, mem_en});
        end
        tick();
        idle_in();
        #1;
        vecs++;
        if ({err0, err1, rvalid0, rvalid1} !== 4'b1000 || bmem[16] !== old) begin
            errs++;
            $display("FAIL mis_err: flags %b mem %h want 1000 mem %h",
                     {err0, err1, rvalid0, rvalid1}, bmem[16], old);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        idle_in();
        req0 = 1; addr0 = 16'h0010;
        tick();
        idle_in();
        rst = 1'b1;
        tick();
        #1;
        vecs++;
        if ({rvalid0, rvalid1, err0, err1, rdata, gnt0, gnt1,
             mem_en, mem_wr, mem_addr, mem_wdata} !== 56'h0) begin
            errs++;
            $display("FAIL rst_mid_read: got %h want 0",
                     {rvalid0, rvalid1, err0, err1, rdata, gnt0, gnt1,
                      mem_en, mem_wr, mem_addr, mem_wdata});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 49) == 0);
            req0   = $urandom_range(0, 2) != 0;
            req1   = $urandom_range(0, 2) != 0;
            wr0    = $urandom_range(0, 1);
            wr1    = $urandom_range(0, 1);
            lock0  = $urandom_range(0, 3) == 0;
            lock1  = $urandom_range(0, 1);
            addr0  = (16'($urandom_range(0, 127)) & 16'hFFFE)
                     | 16'($urandom_range(0, 9) == 0);
            addr1  = (16'($urandom_range(0, 127)) & 16'hFFFE)
                     | 16'($urandom_range(0, 9) == 0);
            wdata0 = 16'($urandom);
            wdata1 = 16'($urandom);
            #1;
            vecs++;
            if ({gnt0, gnt1, mem_en, mem_wr, mem_addr, mem_wdata} !== exp_comb(exp_g())) begin
                errs++;
                $display("FAIL rand_comb%0d: got %h want %h", i,
                         {gnt0, gnt1, mem_en, mem_wr, mem_addr, mem_wdata}, exp_comb(exp_g()));
            end
            vecs++;
            if ({rvalid0, rvalid1, err0, err1, rdata} !== exp_regs()) begin
                errs++;
                $display("FAIL rand_regs%0d: got %h want %h", i,
                         {rvalid0, rvalid1, err0, err1, rdata}, exp_regs());
            end
            tick();
        end
        rst = 1'b0;
        idle_in();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            bmem[i] = 16'($urandom);
            mref[i] = bmem[i];
        end
        @(negedge clk);
        test_reset();
        test_read();
        test_tie();
        test_lock_rmw();
        test_lock_max();
        test_misaligned();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
